tt_logic_lane_array: RTL and testbench

Parametrised, registered per-lane logic unit for the 8-pin user-module slot: each of WIDTH input lanes is independently passed, inverted, XORed with a captured operand, or held/edge-detected, under a runtime configuration shifted in serially and committed atomically. It generalises the fixed "invert low nibble, pass high nibble" user module into a programmable, clocked block. Its reset configuration reproduces that fixed behaviour.

---
 rtl/tt_logic_lane_array.sv | 112 +++++++++++
 tb/tb_tt_logic_lane_array.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_logic_lane_array.sv
// Programmable per-lane logic unit: pass / invert / XOR-with-B / hold-or-edge per lane, serial config with atomic commit.
// Optional: define LOGIC_LANE_EDGE_EN to turn op 11 into a rising-edge detector instead of hold.

module tt_logic_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic       din,
  input  logic       opb_cap,
  output logic       dout
);
  logic b;
  logic nxt;

`ifdef LOGIC_LANE_EDGE_EN
  logic din_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       b <= 1'b0;
    else if (opb_cap) b <= din;

  // XOR uses the B value from before this edge, so a same-cycle capture shows up next cycle
  always_comb begin
    nxt = dout;
    case (op)
      2'b00: nxt = din;
      2'b01: nxt = ~din;
      2'b10: nxt = din ^ b;
`ifdef LOGIC_LANE_EDGE_EN
      2'b11: nxt = din & ~din_q;
`else
      2'b11: nxt = dout;
`endif
      default: nxt = dout;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout <= 1'b0;
    else        dout <= nxt;
endmodule

module tt_logic_lane_array #(
  parameter int WIDTH = 8,
  parameter logic [2*WIDTH-1:0] RESET_CFG = {{(WIDTH-WIDTH/2){2'b00}}, {(WIDTH/2){2'b01}}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             opb_cap,
  input  logic             cfg_sin,
  input  logic             cfg_shift,
  input  logic             cfg_commit,
  output logic [WIDTH-1:0] dout,
  output logic             cfg_full,
  output logic             cfg_err
);
  localparam int CW   = 2*WIDTH;
  localparam int CNTW = $clog2(CW+1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CW);

  typedef enum logic {LOAD = 1'b0, READY = 1'b1} cfg_state_e;

  cfg_state_e            state;
  logic [CNTW-1:0]       cnt;
  logic [CW-1:0]         shadow;
  logic [WIDTH-1:0][1:0] cfg_act;

  // Commit takes priority over shift; a shift in the same cycle is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      shadow   <= '0;
      cfg_act  <= RESET_CFG;
      cfg_full <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (cfg_commit) begin
      if (state == READY) begin
        cfg_act  <= shadow;
        cnt      <= '0;
        state    <= LOAD;
        cfg_full <= 1'b0;
      end else begin
        cfg_err  <= 1'b1;
      end
    end else if (cfg_shift) begin
      shadow <= {cfg_sin, shadow[CW-1:1]};
      if (state == LOAD) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_FULL - 1'b1) begin
          state    <= READY;
          cfg_full <= 1'b1;
        end
      end
    end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    tt_logic_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .op      (cfg_act[i]),
      .din     (din[i]),
      .opb_cap (opb_cap),
      .dout    (dout[i])
    );
  end
endmodule

// File: tb/tb_tt_logic_lane_array.sv
// Directed bench for tt_logic_lane_array at WIDTH=8: vector table plus config-sequence corner cases.

module tb_tt_logic_lane_array;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       opb_cap = 1'b0;
  logic       cfg_sin = 1'b0;
  logic       cfg_shift = 1'b0;
  logic       cfg_commit = 1'b0;
  logic [7:0] dout;
  logic       cfg_full;
  logic       cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] din;
    logic       cap;
    logic [7:0] exp;
  } vec_t;
  vec_t tv[10];

  tt_logic_lane_array #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .opb_cap    (opb_cap),
    .cfg_sin    (cfg_sin),
    .cfg_shift  (cfg_shift),
    .cfg_commit (cfg_commit),
    .dout       (dout),
    .cfg_full   (cfg_full),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] d, input logic cap);
    din = d;
    opb_cap = cap;
    step();
    opb_cap = 1'b0;
  endtask

  // bits[0] goes in first and ends up at shadow bit 0
  task automatic shift_n(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_sin = bits[i];
      cfg_shift = 1'b1;
      step();
    end
    cfg_shift = 1'b0;
    cfg_sin = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset config: low nibble inverted, high nibble passed
    tv[0] = '{8'hA5, 1'b0, 8'hAA};
    tv[1] = '{8'h00, 1'b0, 8'h0F};
    tv[2] = '{8'hFF, 1'b0, 8'hF0};
    tv[3] = '{8'h3C, 1'b0, 8'h33};
    tv[4] = '{8'h5A, 1'b0, 8'h55};
    // all lanes XOR with B = 0F
    tv[5] = '{8'hFF, 1'b0, 8'hF0};
    tv[6] = '{8'h0F, 1'b0, 8'h00};
    tv[7] = '{8'h33, 1'b1, 8'h3C};
    tv[8] = '{8'h33, 1'b0, 8'h00};
    tv[9] = '{8'hA5, 1'b0, 8'h96};

    #3;
    chk("reset_dout", 16'(dout), 16'h00);
    chk("reset_full", 16'(cfg_full), 16'h0);
    chk("reset_err", 16'(cfg_err), 16'h0);
    #4 rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      apply(tv[i].din, tv[i].cap);
      chk($sformatf("rstcfg_vec%0d", i), 16'(dout), 16'(tv[i].exp));
    end

    // all lanes XOR
    din = 8'h00;
    shift_n(16'hAAAA, 15);
    chk("xor_full_15", 16'(cfg_full), 16'h0);
    shift_n(16'h0001, 1);
    chk("xor_full_16", 16'(cfg_full), 16'h1);
    apply(8'h0F, 1'b1);
    chk("xor_cap_oldcfg", 16'(dout), 16'h00);
    cfg_commit = 1'b1;
    apply(8'h0F, 1'b0);
    cfg_commit = 1'b0;
    chk("xor_commit_edge_oldcfg", 16'(dout), 16'h00);
    chk("xor_full_after_commit", 16'(cfg_full), 16'h0);
    for (int i = 5; i < 10; i++) begin
      apply(tv[i].din, tv[i].cap);
      chk($sformatf("xorcfg_vec%0d", i), 16'(dout), 16'(tv[i].exp));
    end
    chk("xor_err", 16'(cfg_err), 16'h0);

    // premature commit
    do_reset();
    din = 8'h00;
    shift_n(16'h0000, 9);
    commit();
    chk("early_err", 16'(cfg_err), 16'h1);
    chk("early_full", 16'(cfg_full), 16'h0);
    apply(8'hA5, 1'b0);
    chk("early_cfg_kept", 16'(dout), 16'hAA);
    shift_n(16'h0000, 7);
    chk("early_full_after7", 16'(cfg_full), 16'h1);
    commit();
    chk("early_full_cleared", 16'(cfg_full), 16'h0);
    chk("early_err_sticky", 16'(cfg_err), 16'h1);
    apply(8'hA5, 1'b0);
    chk("early_pass_cfg", 16'(dout), 16'hA5);

    // op 11: hold, or rising-edge detect when enabled
    do_reset();
    din = 8'h00;
    shift_n(16'hFFFF, 16);
    cfg_commit = 1'b1;
    apply(8'h00, 1'b0);
    cfg_commit = 1'b0;
    chk("op11_commit_edge", 16'(dout), 16'h0F);
    apply(8'h00, 1'b0);
`ifdef LOGIC_LANE_EDGE_EN
    chk("op11_c1", 16'(dout), 16'h00);
    apply(8'hFF, 1'b0);
    chk("op11_c2", 16'(dout), 16'hFF);
    apply(8'hFF, 1'b0);
    chk("op11_c3", 16'(dout), 16'h00);
`else
    chk("op11_c1", 16'(dout), 16'h0F);
    apply(8'hFF, 1'b0);
    chk("op11_c2", 16'(dout), 16'h0F);
    apply(8'hFF, 1'b0);
    chk("op11_c3", 16'(dout), 16'h0F);
`endif

    // shift and commit in the same cycle while READY
    do_reset();
    din = 8'h00;
    shift_n(16'hAAAA, 16);
    cfg_sin = 1'b1;
    cfg_shift = 1'b1;
    cfg_commit = 1'b1;
    step();
    cfg_sin = 1'b0;
    cfg_shift = 1'b0;
    cfg_commit = 1'b0;
    chk("sc_full", 16'(cfg_full), 16'h0);
    chk("sc_err", 16'(cfg_err), 16'h0);
    apply(8'h0F, 1'b1);
    chk("sc_xor_b0", 16'(dout), 16'h0F);
    apply(8'hFF, 1'b0);
    chk("sc_xor_b0f", 16'(dout), 16'hF0);
    shift_n(16'h0000, 15);
    chk("sc_count_15", 16'(cfg_full), 16'h0);
    shift_n(16'h0000, 1);
    chk("sc_count_16", 16'(cfg_full), 16'h1);

    // async reset in the middle of a shift stream
    do_reset();
    apply(8'hFF, 1'b0);
    chk("mid_pre_dout", 16'(dout), 16'hF0);
    shift_n(16'h5555, 10);
    commit();
    chk("mid_pre_err", 16'(cfg_err), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_dout", 16'(dout), 16'h00);
    chk("mid_async_full", 16'(cfg_full), 16'h0);
    chk("mid_async_err", 16'(cfg_err), 16'h0);
    #1 rst_n = 1'b1;
    apply(8'h00, 1'b0);
    chk("mid_post_dout", 16'(dout), 16'h0F);
    shift_n(16'h0000, 15);
    chk("mid_count_15", 16'(cfg_full), 16'h0);
    shift_n(16'h0000, 1);
    chk("mid_count_16", 16'(cfg_full), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
